// File: rtl/gem_kchar_tx.sv
// gem_kchar_tx
// Transmit-side frame-separator generator for one GEM optohybrid fiber.
// Once per 40 MHz frame it emits the K-character checked by the OTMB sync
// monitor. Normal frames rotate BC -> F7 -> FB -> FD. Marker frames override
// the rotation: 1C for BC0, FC for cluster overflow and 3C for resync.
// The block also keeps the BX counter, checks BC0 alignment and can corrupt
// one separator on request, so that the sync monitor can be exercised.
//
// Ports:
//   clock         40 MHz frame clock
//   global_reset  synchronous, active-high reset
//   enable        fiber transmit enable
//   ttc_resync    TTC resync pulse
//   ttc_bc0       TTC BC0 pulse (alignment check, BX counter reload)
//   overflow      more than 8 clusters this BX
//   inject_err    one-shot request to corrupt one separator
//   clr_flags     clears bc0_misalign and err_cnt
//   kchar         registered K-character of the current frame
//   is_bc0        kchar is 1C
//   is_resync     kchar is 3C
//   is_ovf        kchar is FC
//   bx_cnt        BX number of the current frame
//   sync_done     high while in RUN
//   bc0_misalign  sticky: ttc_bc0 seen while bx_cnt != BX_MAX
//   err_cnt       number of injected errors, saturating at 255
module gem_kchar_tx #(
    parameter int          BX_MAX     = 3563,
    parameter int          RESYNC_LEN = 1,
    // Must differ from BC/F7/FB/FD and from the marker characters.
    parameter logic [7:0]  ERR_KCHAR  = 8'hDC
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        enable,
    input  logic        ttc_resync,
    input  logic        ttc_bc0,
    input  logic        overflow,
    input  logic        inject_err,
    input  logic        clr_flags,
    output logic [7:0]  kchar,
    output logic        is_bc0,
    output logic        is_resync,
    output logic        is_ovf,
    output logic [11:0] bx_cnt,
    output logic        sync_done,
    output logic        bc0_misalign,
    output logic [7:0]  err_cnt
);

    localparam logic [11:0] BX_LAST = 12'(BX_MAX);
    localparam logic [3:0]  RS_LEN  = 4'(RESYNC_LEN);

    localparam logic [7:0] K_BC0    = 8'h1C;
    localparam logic [7:0] K_RESYNC = 8'h3C;
    localparam logic [7:0] K_OVF    = 8'hFC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESYNC = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        pend_q, pend_d;
    logic [11:0] bx_q, bx_d;
    logic [7:0]  kchar_q, kchar_d;
    logic        sync_q, sync_d;
    logic        mis_q, mis_d;
    logic [7:0]  err_q, err_d;

    logic [11:0] bx_nxt;
    logic [1:0]  ptr_nxt;
    logic        consume;
    logic        mis_set;

    function automatic logic [7:0] rot_kchar(input logic [1:0] p);
        case (p)
            2'd0:    rot_kchar = 8'hBC;
            2'd1:    rot_kchar = 8'hF7;
            2'd2:    rot_kchar = 8'hFB;
            default: rot_kchar = 8'hFD;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rcnt_d  = rcnt_q;
        bx_d    = bx_q;
        kchar_d = 8'h00;
        consume = 1'b0;
        mis_set = 1'b0;

        // BC0 reloads the counter; otherwise it wraps BX_MAX -> 0.
        if (ttc_bc0) begin
            bx_nxt = 12'd0;
        end else if (bx_q == BX_LAST) begin
            bx_nxt = 12'd0;
        end else begin
            bx_nxt = bx_q + 12'd1;
        end
        ptr_nxt = ptr_q + 2'd1;

        case (state_q)
            IDLE: begin
                bx_d   = 12'd0;
                ptr_d  = 2'd0;
                rcnt_d = 4'd0;
                if (enable && ttc_resync) begin
                    state_d = RESYNC;
                    rcnt_d  = 4'd1;
                    kchar_d = K_RESYNC;
                end
            end
            RESYNC: begin
                bx_d  = 12'd0;
                ptr_d = 2'd0;
                if (ttc_resync) begin
                    // A fresh resync restarts the 3C burst.
                    rcnt_d  = 4'd1;
                    kchar_d = K_RESYNC;
                end else if (rcnt_q == RS_LEN) begin
                    // First RUN frame is BX 0, so it always carries the BC0 marker.
                    state_d = RUN;
                    rcnt_d  = 4'd0;
                    kchar_d = K_BC0;
                end else begin
                    rcnt_d  = rcnt_q + 4'd1;
                    kchar_d = K_RESYNC;
                end
            end
            RUN: begin
                mis_set = ttc_bc0 && (bx_q != BX_LAST);
                if (ttc_resync) begin
                    state_d = RESYNC;
                    rcnt_d  = 4'd1;
                    bx_d    = 12'd0;
                    ptr_d   = 2'd0;
                    kchar_d = K_RESYNC;
                end else if (!enable) begin
                    state_d = IDLE;
                    bx_d    = 12'd0;
                    ptr_d   = 2'd0;
                end else begin
                    // The pointer advances on every frame, markers included,
                    // so the rotation phase never slips.
                    bx_d  = bx_nxt;
                    ptr_d = ptr_nxt;
                    if (bx_nxt == 12'd0) begin
                        kchar_d = K_BC0;
                    end else if (overflow) begin
                        kchar_d = K_OVF;
                    end else if (pend_q) begin
                        kchar_d = ERR_KCHAR;
                        consume = 1'b1;
                    end else begin
                        kchar_d = rot_kchar(ptr_nxt);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sync_d = (state_d == RUN);

        // Repeated requests collapse into one; a request arriving in the
        // consuming cycle stays pending for the next plain frame.
        pend_d = (pend_q && !consume) || inject_err;

        // Set/increment takes precedence over clear.
        if (consume) begin
            err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end else if (clr_flags) begin
            err_d = 8'd0;
        end else begin
            err_d = err_q;
        end

        if (mis_set) begin
            mis_d = 1'b1;
        end else if (clr_flags) begin
            mis_d = 1'b0;
        end else begin
            mis_d = mis_q;
        end
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            rcnt_q  <= 4'd0;
            pend_q  <= 1'b0;
            bx_q    <= 12'd0;
            kchar_q <= 8'h00;
            sync_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
            bx_q    <= bx_d;
            kchar_q <= kchar_d;
            sync_q  <= sync_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign kchar        = kchar_q;
    assign is_bc0       = (kchar_q == K_BC0);
    assign is_resync    = (kchar_q == K_RESYNC);
    assign is_ovf       = (kchar_q == K_OVF);
    assign bx_cnt       = bx_q;
    assign sync_done    = sync_q;
    assign bc0_misalign = mis_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_gem_kchar_tx.sv
// Self-checking bench for gem_kchar_tx: a frame-level reference model tracks
// the expected separator stream; a compare process checks every frame, and
// directed sections pin known sequences with literal values.
module tb_gem_kchar_tx;

    localparam int BX_MAX     = 3563;
    localparam int RESYNC_LEN = 1;
    localparam logic [7:0] ERR_K = 8'hDC;

    logic        clk = 1'b0;
    logic        global_reset, enable, ttc_resync, ttc_bc0;
    logic        overflow, inject_err, clr_flags;
    logic [7:0]  kchar;
    logic        is_bc0, is_resync, is_ovf;
    logic [11:0] bx_cnt;
    logic        sync_done, bc0_misalign;
    logic [7:0]  err_cnt;

    int vecs = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    gem_kchar_tx #(
        .BX_MAX(BX_MAX),
        .RESYNC_LEN(RESYNC_LEN),
        .ERR_KCHAR(ERR_K)
    ) dut (
        .clock(clk),
        .global_reset(global_reset),
        .enable(enable),
        .ttc_resync(ttc_resync),
        .ttc_bc0(ttc_bc0),
        .overflow(overflow),
        .inject_err(inject_err),
        .clr_flags(clr_flags),
        .kchar(kchar),
        .is_bc0(is_bc0),
        .is_resync(is_resync),
        .is_ovf(is_ovf),
        .bx_cnt(bx_cnt),
        .sync_done(sync_done),
        .bc0_misalign(bc0_misalign),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame level) ----------------
    // mode: 0 = idle, 1 = sending resync burst, 2 = running
    int         m_mode = 0;
    int         m_bx = 0;
    int         m_slot = 0;
    int         m_burst = 0;
    bit         m_pend = 0;
    int         m_err = 0;
    bit         m_mis = 0;
    logic [7:0] m_k = 8'h00;
    logic [7:0] rot_tab [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

    always @(posedge clk) begin
        bit used, flag;
        int nbx;
        used = 0;
        flag = 0;
        if (global_reset) begin
            m_mode = 0; m_bx = 0; m_slot = 0; m_burst = 0;
            m_pend = 0; m_err = 0; m_mis = 0; m_k = 8'h00;
        end else begin
            if (m_mode == 0) begin
                m_k = 8'h00;
                if (enable && ttc_resync) begin
                    m_mode = 1; m_burst = 1; m_k = 8'h3C;
                end
            end else if (m_mode == 1) begin
                if (ttc_resync) begin
                    m_burst = 1; m_k = 8'h3C;
                end else if (m_burst >= RESYNC_LEN) begin
                    m_mode = 2; m_bx = 0; m_slot = 0; m_k = 8'h1C;
                end else begin
                    m_burst++; m_k = 8'h3C;
                end
            end else begin
                if (ttc_bc0 && m_bx != BX_MAX) flag = 1;
                nbx = ttc_bc0 ? 0 : (m_bx + 1) % (BX_MAX + 1);
                if (ttc_resync) begin
                    m_mode = 1; m_burst = 1; m_k = 8'h3C; m_bx = 0; m_slot = 0;
                end else if (!enable) begin
                    m_mode = 0; m_k = 8'h00; m_bx = 0; m_slot = 0;
                end else begin
                    m_bx = nbx;
                    m_slot = (m_slot + 1) % 4;
                    if (m_bx == 0) m_k = 8'h1C;
                    else if (overflow) m_k = 8'hFC;
                    else if (m_pend) begin m_k = ERR_K; used = 1; end
                    else m_k = rot_tab[m_slot];
                end
            end
            m_pend = (m_pend && !used) || inject_err;
            if (used) m_err = (m_err >= 255) ? 255 : m_err + 1;
            else if (clr_flags) m_err = 0;
            if (flag) m_mis = 1;
            else if (clr_flags) m_mis = 0;
        end
    end

    // ---------------- per-frame compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            vecs++;
            if (kchar !== m_k || is_bc0 !== (m_k == 8'h1C) || is_resync !== (m_k == 8'h3C)
                || is_ovf !== (m_k == 8'hFC) || bx_cnt !== 12'(m_bx)
                || sync_done !== (m_mode == 2) || bc0_misalign !== m_mis
                || err_cnt !== 8'(m_err)) begin
                fails++;
                $display("FAIL frame t=%0t: kchar=%h exp %h flags(bc0,rs,ovf)=%b%b%b bx=%0d exp %0d sync=%b exp %b mis=%b exp %b err=%0d exp %0d",
                         $time, kchar, m_k, is_bc0, is_resync, is_ovf, bx_cnt, m_bx,
                         sync_done, (m_mode == 2), bc0_misalign, m_mis, err_cnt, m_err);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_to_bx(input int target, input string nm);
        int n;
        n = 0;
        while (bx_cnt !== 12'(target) && n < 5000) begin
            tick();
            n++;
        end
        if (bx_cnt !== 12'(target)) begin
            vecs++;
            fails++;
            $display("FAIL %s: timeout waiting for bx %0d, bx=%0d", nm, target, bx_cnt);
        end
    endtask

    initial begin
        logic [7:0] seq1 [5];
        seq1 = '{8'hF7, 8'hFB, 8'hFD, 8'hBC, 8'hF7};

        global_reset = 1'b1; enable = 1'b0; ttc_resync = 1'b0; ttc_bc0 = 1'b0;
        overflow = 1'b0; inject_err = 1'b0; clr_flags = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_kchar", 32'(kchar), 32'h00);
        chk("reset_sync", 32'(sync_done), 0);
        chk("reset_bx", 32'(bx_cnt), 0);
        chk("reset_err", 32'(err_cnt), 0);

        // Resync into RUN: 3C, 1C, F7, FB, FD, BC, F7
        global_reset = 1'b0; enable = 1'b1; ttc_resync = 1'b1;
        tick(); ttc_resync = 1'b0;
        chk("t1_3c", 32'(kchar), 32'h3C);
        chk("t1_is_resync", 32'(is_resync), 1);
        chk("t1_sync_low", 32'(sync_done), 0);
        tick();
        chk("t1_1c", 32'(kchar), 32'h1C);
        chk("t1_sync_high", 32'(sync_done), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_rot", 32'(kchar), 32'(seq1[i]));
        end
        chk("t1_bx5", 32'(bx_cnt), 5);

        // Overflow at the ptr=2 frame, rotation continues
        overflow = 1'b1; tick(); overflow = 1'b0;
        chk("t2_fc", 32'(kchar), 32'hFC);
        chk("t2_is_ovf", 32'(is_ovf), 1);
        chk("t2_bx6", 32'(bx_cnt), 6);
        tick(); chk("t2_fd", 32'(kchar), 32'hFD);
        tick(); chk("t2_bc", 32'(kchar), 32'hBC);

        // BX wrap, overflow at bx 0 loses to BC0
        run_to_bx(BX_MAX, "t3_wait");
        overflow = 1'b1; tick(); overflow = 1'b0;
        chk("t3_wrap_bx", 32'(bx_cnt), 0);
        chk("t3_wrap_1c", 32'(kchar), 32'h1C);
        chk("t3_no_ovf", 32'(is_ovf), 0);

        // Misaligned BC0, clear, aligned BC0
        run_to_bx(100, "t4_wait100");
        ttc_bc0 = 1'b1; tick(); ttc_bc0 = 1'b0;
        chk("t4_bc0_bx", 32'(bx_cnt), 0);
        chk("t4_mis_set", 32'(bc0_misalign), 1);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("t4_mis_clr", 32'(bc0_misalign), 0);
        run_to_bx(BX_MAX, "t4_waitmax");
        ttc_bc0 = 1'b1; tick(); ttc_bc0 = 1'b0;
        chk("t4_aligned_bx", 32'(bx_cnt), 0);
        chk("t4_aligned_mis", 32'(bc0_misalign), 0);

        // Injection requested twice in IDLE -> exactly one DC
        global_reset = 1'b1; tick(); global_reset = 1'b0;
        inject_err = 1'b1; tick(); inject_err = 1'b0; tick();
        inject_err = 1'b1; tick(); inject_err = 1'b0; tick();
        chk("t5_idle", 32'(kchar), 32'h00);
        ttc_resync = 1'b1; tick(); ttc_resync = 1'b0;
        chk("t5_3c", 32'(kchar), 32'h3C);
        tick(); chk("t5_1c", 32'(kchar), 32'h1C);
        tick(); chk("t5_dc", 32'(kchar), 32'hDC);
        chk("t5_err1", 32'(err_cnt), 1);
        tick(); chk("t5_fb", 32'(kchar), 32'hFB);
        tick(); chk("t5_fd", 32'(kchar), 32'hFD);
        chk("t5_err_still1", 32'(err_cnt), 1);

        // Reset mid-RUN, enable drop, resync ignored while disabled
        tick(); tick();
        global_reset = 1'b1; tick(); global_reset = 1'b0;
        chk("t6_rst_k", 32'(kchar), 32'h00);
        chk("t6_rst_sync", 32'(sync_done), 0);
        ttc_resync = 1'b1; tick(); ttc_resync = 1'b0;
        tick(); tick(); tick();
        chk("t6_running", 32'(sync_done), 1);
        enable = 1'b0; tick();
        chk("t6_dis_k", 32'(kchar), 32'h00);
        chk("t6_dis_sync", 32'(sync_done), 0);
        ttc_resync = 1'b1; tick(); ttc_resync = 1'b0;
        chk("t6_stay_idle", 32'(kchar), 32'h00);
        chk("t6_stay_sync", 32'(sync_done), 0);

        // Randomized traffic against the model
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            enable       = ($urandom_range(0, 99) < 97);
            ttc_resync   = ($urandom_range(0, 99) < 2);
            ttc_bc0      = ($urandom_range(0, 199) < 1);
            overflow     = ($urandom_range(0, 99) < 10);
            inject_err   = ($urandom_range(0, 99) < 4);
            clr_flags    = ($urandom_range(0, 99) < 2);
            global_reset = ($urandom_range(0, 999) < 2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/gem_kchar_tx.md
Name: gem_kchar_tx

Overview:
- Transmit-side frame-separator generator for one GEM optohybrid fiber.
- Produces, once per 40 MHz frame, the 8-bit K-character that the OTMB sync monitor checks.
- Normal frames rotate BC→F7→FB→FD. Markers override the rotation: FC for cluster overflow, 1C for BC0, 3C for resync.
- Used in the GEM link emulator / loopback test path. It also provides BX counting, BC0 alignment checking and error injection for sync-monitor verification.

Parameters:
- BX_MAX, 3563: last BX index; the BX counter wraps BX_MAX→0.
- RESYNC_LEN, 1: number of 3C frames emitted per resync, range 1..15.
- ERR_KCHAR, 8'hDC: injected illegal separator; must not be in the rotation table.

Ports:
- clock  in  1  40 MHz frame clock
- global_reset  in  1  synchronous, active-high reset
- enable  in  1  fiber transmit enable
- ttc_resync  in  1  TTC resync pulse
- ttc_bc0  in  1  TTC BC0 pulse, used for alignment
- overflow  in  1  more than 8 clusters this BX, from the cluster packer
- inject_err  in  1  one-shot request to corrupt one separator
- clr_flags  in  1  clears the sticky flags and the error counter
- kchar  out  8  registered K-character for this frame
- is_bc0  out  1  kchar is 1C
- is_resync  out  1  kchar is 3C
- is_ovf  out  1  kchar is FC
- bx_cnt  out  12  current BX number
- sync_done  out  1  high while in RUN
- bc0_misalign  out  1  sticky: ttc_bc0 arrived when bx_cnt≠BX_MAX
- err_cnt  out  8  number of injected errors, saturates at 255

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (global_reset).
- Reset values:
  - kchar=8'h00; is_bc0, is_resync, is_ovf, sync_done, bc0_misalign = 0.
  - bx_cnt=0, err_cnt=0.
  - state=IDLE, rotation pointer ptr=0, resync counter=0, pending-injection flag=0.
- Latency: all outputs are registered. An input sampled in cycle N affects kchar in cycle N+1.
- State IDLE:
  - kchar=8'h00, sync_done=0, bx_cnt held at 0.
  - Goes to RESYNC when enable & ttc_resync.
- State RESYNC:
  - kchar=8'h3C and is_resync=1 for RESYNC_LEN cycles.
  - ptr forced to 0, bx_cnt forced to 0, sync_done=0.
  - Goes to RUN after the RESYNC_LEN-th 3C frame.
  - A ttc_resync arriving during RESYNC restarts the 3C count.
- State RUN:
  - sync_done=1.
  - Every cycle bx_cnt advances, wrapping BX_MAX→0.
  - ptr advances mod 4 every cycle, including marker and error frames, so the rotation never stalls.
  - Rotation table by ptr: 0=BC, 1=F7, 2=FB, 3=FD.
- RUN output priority, highest first:
  - ttc_resync: go to RESYNC; the next kchar is 3C.
  - enable low: go to IDLE; the next kchar is 00.
  - bx_cnt==0: kchar=1C, is_bc0=1.
  - overflow: kchar=FC, is_ovf=1.
  - pending injection: kchar=ERR_KCHAR, clear the pending flag, increment err_cnt (saturating).
  - otherwise: kchar=table[ptr].
- Overflow and BC0 in the same frame: 1C is sent and the overflow indication is dropped.
- Injection:
  - inject_err sets the pending flag in any state. The flag is consumed only by the first plain-rotation frame in RUN.
  - Multiple inject_err pulses before consumption collapse into one.
- ttc_bc0 in RUN: bx_cnt loads 0 next cycle. bc0_misalign is set if bx_cnt≠BX_MAX at the time. ttc_bc0 is ignored outside RUN.
- clr_flags clears bc0_misalign and err_cnt. If clr_flags and a set/increment event occur in the same cycle, the set/increment wins.
- global_reset during any state returns all registers to their reset values on the next edge.

Test Plan:
1. Reset, then enable=1 and a 1-cycle ttc_resync, RESYNC_LEN=1 → kchar sequence 3C, 1C, F7, FB, FD, BC, F7; sync_done rises with the 1C frame.
2. overflow pulsed so it is sampled at the frame where ptr=2 (bx=6) → FC with is_ovf=1, then FD, BC; the rotation is unbroken.
3. Run 3564 frames after resync → 1C at frames 0 and 3564, bx_cnt wraps 3563→0. overflow asserted at bx 0 → 1C and is_ovf=0.
4. ttc_bc0 pulsed at bx_cnt=100 → bx_cnt=0 next cycle, bc0_misalign=1. After clr_flags → 0. ttc_bc0 at bx 3563 → no flag.
5. inject_err twice while in IDLE, then resync → exactly one DC frame (the first non-marker RUN frame), err_cnt=1, following frame continues the rotation.
6. global_reset mid-RUN → kchar=00 and sync_done=0 next cycle. enable dropped in RUN → 00 and IDLE; ttc_resync with enable=0 → stays IDLE.
